// File: rtl/uart_tx_packer_if.sv
// Recovered-bit input and UART/status output bundle of the tx packer.
// The sink drives bit_valid/bit_in; the packer returns the serial line and status.
interface uart_tx_packer_if #(
    parameter int unsigned CNT_W = 8
);
    logic             bit_valid;
    logic             bit_in;
    logic             tx;
    logic             busy;
    logic             overflow;
    logic [CNT_W-1:0] drop_cnt;

    modport master (output bit_valid, bit_in, input tx, busy, overflow, drop_cnt);
    modport slave  (input bit_valid, bit_in, output tx, busy, overflow, drop_cnt);
endinterface

// File: rtl/uart_tx_packer.sv
// Packs recovered bits LSB-first into bytes, buffers them in a small FIFO and
// re-serialises each byte as an 8N1 UART frame on tx.
module uart_tx_packer #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_packer_if.slave bus
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        shreg_q, shreg_d;
    logic [7:0]        new_byte;
    logic              byte_done;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [7:0]        mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              full, pop, push, drop;

    state_e            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        txsh_q, txsh_d;
    logic              baud_end;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    // Bit packer: the 8th bit completes the byte straight into the FIFO path
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        byte_done = 1'b0;
        new_byte  = {bus.bit_in, shreg_q};
        if (bus.bit_valid) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                byte_done = 1'b1;
            end else begin
                shreg_d[bit_cnt_q] = bus.bit_in;
            end
        end
    end

    // A pop in the same edge frees a slot, so a push into a full FIFO still lands
    assign full = (occ_q == OCC_W'(FIFO_DEPTH));
    assign pop  = (state_q == IDLE) && (occ_q != '0);
    assign push = byte_done && (!full || pop);
    assign drop = byte_done && full && !pop;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        overflow_d = drop;
        drop_cnt_d = drop_cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = new_byte;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - OCC_W'(1);
        end
        if (drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    // Frame serialiser; txsh shifts right so the next data bit is always at [1]
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        idx_d    = idx_q;
        txsh_d   = txsh_q;
        tx_d     = tx_q;
        baud_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    txsh_d  = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    idx_d   = '0;
                    tx_d    = txsh_q[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        txsh_d = txsh_q >> 1;
                        tx_d   = txsh_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE) || (occ_d != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            state_q    <= IDLE;
            baud_q     <= '0;
            idx_q      <= '0;
            txsh_q     <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            idx_q      <= idx_d;
            txsh_q     <= txsh_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.tx       = tx_q;
    assign bus.busy     = busy_q;
    assign bus.overflow = overflow_q;
    assign bus.drop_cnt = drop_cnt_q;

endmodule
